// File: rtl/csd_encoder_if.sv
// csd_encoder_if: request and digit-write bus of the CSD encoder.
//   start, binIn    : encode request and operand (requester -> encoder)
//   weCsd, csdAddr,
//   csdData         : digit-memory write port (encoder -> memory)
//   busy, done      : encode status
//   nzCount,
//   tooMany         : nonzero-digit statistics of the last completed encode
// master = requester side, slave = encoder side.
interface csd_encoder_if;
    logic        start;
    logic [14:0] binIn;
    logic        weCsd;
    logic [3:0]  csdAddr;
    logic [7:0]  csdData;
    logic        busy;
    logic        done;
    logic [3:0]  nzCount;
    logic        tooMany;

    modport master (
        output start, binIn,
        input  weCsd, csdAddr, csdData, busy, done, nzCount, tooMany
    );

    modport slave (
        input  start, binIn,
        output weCsd, csdAddr, csdData, busy, done, nzCount, tooMany
    );
endinterface

// File: rtl/csd_encoder.sv
// csd_encoder: recodes a 15-bit unsigned operand into 16 canonical signed
// digits (+1 / 0 / -1) and writes them, one per cycle, to a digit memory.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-low reset
//   bus   : csd_encoder_if.slave (request, digit-write port, status)
//
// state | meaning
// IDLE  | waiting for start; operand captured on the accepted start
// ENC   | writing digit idx each cycle, idx 0..15
// DONE  | one cycle after the last write: done pulse, statistics updated
module csd_encoder (
    input  logic          clk,
    input  logic          reset,
    csd_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t      state_q, state_d;
    logic [14:0] x_q, x_d;
    logic        carry_q, carry_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  nz_q, nz_d;
    logic        tm_q, tm_d;

    // Zero-extended operand so that x15 = x16 = 0 fall out of plain indexing.
    logic [31:0] x_ext;
    logic [4:0]  pos;
    logic        x_i, x_n;
    logic        dig_nz, dig_neg, carry_nxt;
    logic [7:0]  dig_val;

    always_comb begin
        x_ext     = {17'd0, x_q};
        pos       = {1'b0, idx_q};
        x_i       = x_ext[pos];
        x_n       = x_ext[pos + 5'd1];
        // s = x_i + carry is 1 exactly when they differ; the next bit then
        // chooses +1 (no carry) or -1 (carry) to break runs of ones.
        dig_nz    = x_i ^ carry_q;
        dig_neg   = dig_nz & x_n;
        carry_nxt = (x_i & carry_q) | dig_neg;
        dig_val   = dig_nz ? (dig_neg ? 8'hFF : 8'h01) : 8'h00;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nz_d    = nz_q;
        tm_d    = tm_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.binIn;
                    carry_d = 1'b0;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ENC;
                end
            end
            ENC: begin
                we_d    = 1'b1;
                addr_d  = idx_q;
                data_d  = dig_val;
                carry_d = carry_nxt;
                idx_d   = idx_q + 4'd1;
                cnt_d   = cnt_q + {3'd0, dig_nz};
                if (idx_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                nz_d    = cnt_q;
                tm_d    = (cnt_q > 4'd4);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nz_q    <= '0;
            tm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nz_q    <= nz_d;
            tm_q    <= tm_d;
        end
    end

    assign bus.weCsd   = we_q;
    assign bus.csdAddr = addr_q;
    assign bus.csdData = data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.nzCount = nz_q;
    assign bus.tooMany = tm_q;
endmodule
